// File: rtl/encoder16_scan_pkg.sv
// Shared widths and state encoding for the encoder16_scan block and its
// lowest-set-bit encoder.
package encoder16_scan_pkg;

   localparam int N = 16;
   localparam int W = 4;

   localparam logic [N-1:0] ONE_HOT_LSB = {{(N-1){1'b0}}, 1'b1};

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_e;

endpackage

// File: rtl/encoder16_scan_pri_enc16.sv
// Combinational lowest-set-bit encoder: reports the index of the lowest set bit,
// whether any bit is set, and whether exactly one bit is set.
module pri_enc16
   import encoder16_scan_pkg::*;
(
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         any,
   output logic         single
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = W'(i);
         end
      end
   end

   // Clearing the lowest set bit leaves nothing only when one bit was set.
   assign any    = |vec;
   assign single = any && ((vec & (vec - ONE_HOT_LSB)) == '0);

endmodule

// File: rtl/encoder16_scan.sv
// Captures a request vector and emits the index of every set bit, lowest first,
// one beat per accepted output transfer; an all-zero vector yields one flagged beat.
module encoder16_scan
   import encoder16_scan_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] in,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_last,
   output logic         out_zero,
   output logic         busy
);

   state_e         state_q;
   logic [N-1:0]   pending_q;
   logic           zero_q;

   logic [W-1:0]   lowIdx;
   logic           anySet;
   logic           singleSet;

   pri_enc16 u_pri_enc16 (
      .vec    (pending_q),
      .idx    (lowIdx),
      .any    (anySet),
      .single (singleSet)
   );

   // Every output is decoded from registered state only, never from the input vector.
   assign in_ready  = (state_q == ST_IDLE);
   assign busy      = (state_q == ST_EMIT);
   assign out_valid = (state_q == ST_EMIT);
   assign out       = lowIdx;
   assign out_zero  = (state_q == ST_EMIT) && zero_q;
   assign out_last  = (state_q == ST_EMIT) && (singleSet || zero_q);

   // Handshake FSM; the pending vector loses one bit per accepted beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
         zero_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  pending_q <= in;
                  zero_q    <= (in == '0);
                  state_q   <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (out_ready) begin
                  if (anySet) begin
                     pending_q <= pending_q & ~(ONE_HOT_LSB << lowIdx);
                  end
                  if (out_last) begin
                     zero_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_encoder16_scan.sv
// Directed self-checking bench for encoder16_scan: round trip, multi-bit, zero,
// backpressure, full vector and mid-vector reset.
module tb_encoder16_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  out;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        out_zero;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   encoder16_scan dut (
      .clk       (clk),
      .rst       (rst),
      .in        (in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out       (out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .out_zero  (out_zero),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Advance one clock edge, then settle 1 time unit so outputs and new inputs are away from the edge.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      int busyCycles;
      logic [3:0] multiIdx [4];
      multiIdx = '{4'd0, 4'd5, 4'd10, 4'd15};

      rst       = 1'b1;
      in        = '0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      applyStimulus();
      applyStimulus();
      rst = 1'b0;
      checkOutput("reset_in_ready",  in_ready,  1);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_busy",      busy,      0);
      checkOutput("reset_out",       out,       0);
      checkOutput("reset_out_last",  out_last,  0);
      checkOutput("reset_out_zero",  out_zero,  0);

      $display("[TB] round trip through one-hot codes");
      for (int k = 0; k < 16; k++) begin
         in       = 16'h0001 << k;
         in_valid = 1'b1;
         applyStimulus();
         in_valid = 1'b0;
         checkOutput($sformatf("rt_out_%0d", k),      out,       k);
         checkOutput($sformatf("rt_valid_%0d", k),    out_valid, 1);
         checkOutput($sformatf("rt_last_%0d", k),     out_last,  1);
         checkOutput($sformatf("rt_zero_%0d", k),     out_zero,  0);
         checkOutput($sformatf("rt_in_ready_%0d", k), in_ready,  0);
         applyStimulus();
         checkOutput($sformatf("rt_idle_%0d", k),     in_ready,  1);
      end

      $display("[TB] multi-bit vector 8421");
      in       = 16'h8421;
      in_valid = 1'b1;
      applyStimulus();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("mb_out_%0d", i),   out,       multiIdx[i]);
         checkOutput($sformatf("mb_valid_%0d", i), out_valid, 1);
         checkOutput($sformatf("mb_last_%0d", i),  out_last,  (i == 3) ? 1 : 0);
         applyStimulus();
      end
      checkOutput("mb_in_ready_after", in_ready,  1);
      checkOutput("mb_valid_after",    out_valid, 0);

      $display("[TB] zero vector");
      in       = 16'h0000;
      in_valid = 1'b1;
      applyStimulus();
      in_valid = 1'b0;
      checkOutput("zero_out",   out,       0);
      checkOutput("zero_valid", out_valid, 1);
      checkOutput("zero_flag",  out_zero,  1);
      checkOutput("zero_last",  out_last,  1);
      applyStimulus();
      checkOutput("zero_idle",  in_ready,  1);

      $display("[TB] backpressure on 0006");
      in        = 16'h0006;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      applyStimulus();
      in_valid = 1'b0;
      in       = 16'hFFFF;
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("bp_hold_out_%0d", i),  out,      1);
         checkOutput($sformatf("bp_hold_last_%0d", i), out_last, 0);
         checkOutput($sformatf("bp_in_ready_%0d", i),  in_ready, 0);
         applyStimulus();
      end
      out_ready = 1'b1;
      checkOutput("bp_first_out",  out,      1);
      applyStimulus();
      checkOutput("bp_second_out", out,      2);
      checkOutput("bp_second_last", out_last, 1);
      checkOutput("bp_in_ready",   in_ready, 0);
      applyStimulus();
      checkOutput("bp_idle",       in_ready, 1);

      $display("[TB] full vector FFFF");
      in       = 16'hFFFF;
      in_valid = 1'b1;
      applyStimulus();
      in_valid   = 1'b0;
      busyCycles = 0;
      for (int i = 0; i < 16; i++) begin
         if (busy === 1'b1) busyCycles++;
         checkOutput($sformatf("full_out_%0d", i),  out,      i);
         checkOutput($sformatf("full_last_%0d", i), out_last, (i == 15) ? 1 : 0);
         applyStimulus();
      end
      checkOutput("full_busy_cycles", busyCycles, 16);
      checkOutput("full_busy_after",  busy,       0);
      checkOutput("full_idle",        in_ready,   1);

      $display("[TB] reset in the middle of 00F0");
      in       = 16'h00F0;
      in_valid = 1'b1;
      applyStimulus();
      in_valid = 1'b0;
      checkOutput("mid_first_out", out, 4);
      applyStimulus();
      checkOutput("mid_second_out", out, 5);
      rst = 1'b1;
      applyStimulus();
      rst = 1'b0;
      checkOutput("mid_rst_valid",    out_valid, 0);
      checkOutput("mid_rst_in_ready", in_ready,  1);
      in       = 16'h0002;
      in_valid = 1'b1;
      applyStimulus();
      in_valid = 1'b0;
      checkOutput("mid_new_out",  out,      1);
      checkOutput("mid_new_last", out_last, 1);
      checkOutput("mid_new_zero", out_zero, 0);
      applyStimulus();
      checkOutput("mid_new_idle", in_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
